// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and load/store,
// one transaction in flight, with a starvation guard for fetch.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  input  logic [ADDR_WIDTH-1:0] ifu_req_addr,
  output logic                  ifu_req_ready,
  output logic                  ifu_resp_valid,
  output logic [DATA_WIDTH-1:0] ifu_resp_data,
  input  logic                  lsu_req_valid,
  input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
  input  logic                  lsu_req_wen,
  input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
  input  logic [7:0]            lsu_req_wmask,
  output logic                  lsu_req_ready,
  output logic                  lsu_resp_valid,
  output logic [DATA_WIDTH-1:0] lsu_resp_data,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_wen,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  output logic [7:0]            mem_req_wmask,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic                  busy
);

  localparam int CW =
    (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [7:0]            wmask;
  } memReq_t;

  state_t          state;
  state_t          nextState;
  memReq_t         reqQ;
  logic            ownerLsu;
  logic [CW-1:0]   starveCnt;
  logic            starved;
  logic            grantIfu;
  logic            grantLsu;
  logic            respFire;

  assign starved = (starveCnt == LIM);

  // Fetch only beats a pending load/store once it has waited too long.
  always_comb begin
    grantIfu = 1'b0;
    grantLsu = 1'b0;
    if (state == IDLE && !rst) begin
      unique case (1'b1)
        ifu_req_valid && (starved || !lsu_req_valid):
          grantIfu = 1'b1;
        lsu_req_valid && !(ifu_req_valid && starved):
          grantLsu = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (grantIfu || grantLsu) nextState = REQ;
      REQ:  if (mem_req_ready) nextState = WAIT;
      WAIT: if (mem_resp_valid) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reqQ      <= '0;
      ownerLsu  <= 1'b0;
      starveCnt <= '0;
    end else if (grantLsu) begin
      reqQ.addr  <= lsu_req_addr;
      reqQ.wen   <= lsu_req_wen;
      reqQ.wdata <= lsu_req_wdata;
      reqQ.wmask <= lsu_req_wmask;
      ownerLsu   <= 1'b1;
      if (ifu_req_valid && !starved) begin
        starveCnt <= starveCnt + CW'(1);
      end
    end else if (grantIfu) begin
      reqQ.addr  <= ifu_req_addr;
      reqQ.wen   <= 1'b0;
      reqQ.wdata <= '0;
      reqQ.wmask <= '0;
      ownerLsu   <= 1'b0;
      starveCnt  <= '0;
    end
  end

  // Responses only count while a transaction is waiting on memory.
  always_comb begin
    respFire       = (state == WAIT) && mem_resp_valid;
    ifu_req_ready  = grantIfu;
    lsu_req_ready  = grantLsu;
    mem_req_valid  = (state == REQ);
    ifu_resp_valid = respFire && !ownerLsu;
    lsu_resp_valid = respFire && ownerLsu;
    ifu_resp_data  = ifu_resp_valid ? mem_resp_data : '0;
    lsu_resp_data  = lsu_resp_valid ? mem_resp_data : '0;
    busy           = (state != IDLE);
  end

  assign mem_req_addr  = reqQ.addr;
  assign mem_req_wen   = reqQ.wen;
  assign mem_req_wdata = reqQ.wdata;
  assign mem_req_wmask = reqQ.wmask;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifuV;
  logic [AW-1:0] ifuAddr;
  logic          ifuRdy;
  logic          ifuRespV;
  logic [DW-1:0] ifuRespD;
  logic          lsuV;
  logic [AW-1:0] lsuAddr;
  logic          lsuWen;
  logic [DW-1:0] lsuWdata;
  logic [7:0]    lsuWmask;
  logic          lsuRdy;
  logic          lsuRespV;
  logic [DW-1:0] lsuRespD;
  logic          memV;
  logic [AW-1:0] memAddr;
  logic          memWen;
  logic [DW-1:0] memWdata;
  logic [7:0]    memWmask;
  logic          memRdy;
  logic          memRespV;
  logic [DW-1:0] memRespD;
  logic          busy;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ifu_req_valid(ifuV),
    .ifu_req_addr(ifuAddr),
    .ifu_req_ready(ifuRdy),
    .ifu_resp_valid(ifuRespV),
    .ifu_resp_data(ifuRespD),
    .lsu_req_valid(lsuV),
    .lsu_req_addr(lsuAddr),
    .lsu_req_wen(lsuWen),
    .lsu_req_wdata(lsuWdata),
    .lsu_req_wmask(lsuWmask),
    .lsu_req_ready(lsuRdy),
    .lsu_resp_valid(lsuRespV),
    .lsu_resp_data(lsuRespD),
    .mem_req_valid(memV),
    .mem_req_addr(memAddr),
    .mem_req_wen(memWen),
    .mem_req_wdata(memWdata),
    .mem_req_wmask(memWmask),
    .mem_req_ready(memRdy),
    .mem_resp_valid(memRespV),
    .mem_resp_data(memRespD),
    .busy(busy)
  );

  typedef struct packed {
    logic          lsu;
    logic [AW-1:0] addr;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [7:0]    wmask;
  } txn_t;

  // Model: the transaction in flight, whether memory took it yet,
  // and how many LSU grants fetch has sat through.
  txn_t        cur;
  bit          active;
  bit          sent;
  int          streak;
  int          grantCnt;
  logic [63:0] grantLog;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clearIn();
    ifuV = 0; ifuAddr = '0;
    lsuV = 0; lsuAddr = '0; lsuWen = 0;
    lsuWdata = '0; lsuWmask = '0;
    memRdy = 0; memRespV = 0; memRespD = '0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    chk("rst_ifu_ready", ifuRdy, 0);
    chk("rst_lsu_ready", lsuRdy, 0);
    chk("rst_mem_valid", memV, 0);
    chk("rst_mem_addr", memAddr, 0);
    chk("rst_mem_wen", memWen, 0);
    chk("rst_mem_wdata", memWdata, 0);
    chk("rst_mem_wmask", memWmask, 0);
    chk("rst_ifu_resp", ifuRespV, 0);
    chk("rst_lsu_resp", lsuRespV, 0);
    chk("rst_ifu_data", ifuRespD, 0);
    chk("rst_lsu_data", lsuRespD, 0);
    chk("rst_busy", busy, 0);
    active = 0; sent = 0; streak = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: check outputs against the model, then advance it.
  task automatic cycle();
    bit gI, gL, eResp;
    gI = 0; gL = 0;
    #1;
    if (!active) begin
      if (ifuV && lsuV) begin
        if (streak == LIM) gI = 1; else gL = 1;
      end else if (ifuV) gI = 1;
      else if (lsuV) gL = 1;
    end
    eResp = active && sent && memRespV;
    chk("ifu_ready", ifuRdy, gI);
    chk("lsu_ready", lsuRdy, gL);
    chk("busy", busy, active);
    chk("mem_valid", memV, active && !sent);
    if (active && !sent) begin
      chk("mem_addr", memAddr, cur.addr);
      chk("mem_wen", memWen, cur.wen);
      chk("mem_wmask", memWmask, cur.wmask);
      if (cur.wen) chk("mem_wdata", memWdata, cur.wdata);
    end
    chk("ifu_resp_valid", ifuRespV, eResp && !cur.lsu);
    chk("lsu_resp_valid", lsuRespV, eResp && cur.lsu);
    if (eResp && cur.lsu) chk("lsu_resp_data", lsuRespD, memRespD);
    if (eResp && !cur.lsu) chk("ifu_resp_data", ifuRespD, memRespD);
    @(posedge clk);
    if (gI || gL) begin
      active = 1; sent = 0;
      grantCnt++;
      grantLog = {grantLog[62:0], gI};
      if (gI) begin
        cur = '{lsu: 0, addr: ifuAddr, wen: 0, wdata: '0, wmask: '0};
        streak = 0;
      end else begin
        cur = '{lsu: 1, addr: lsuAddr, wen: lsuWen,
                wdata: lsuWdata, wmask: lsuWmask};
        if (ifuV && streak < LIM) streak++;
      end
    end else if (active && !sent && memRdy) begin
      sent = 1;
    end else if (eResp) begin
      active = 0;
    end
    @(negedge clk);
  endtask

  task automatic runTxn();
    for (int k = 0; k < 10 && active; k++) begin
      memRdy = 1;
      memRespV = sent;
      memRespD = {$urandom, $urandom};
      cycle();
    end
    memRdy = 0; memRespV = 0;
    #1;
    chk("txn_drained_busy", busy, 0);
  endtask

  initial begin
    grantCnt = 0; grantLog = '0;
    clearIn();
    ifuV = 1; lsuV = 1;
    doReset();
    clearIn();

    // Single fetch with a ready memory.
    ifuV = 1; ifuAddr = 64'h8000_0000; memRdy = 1;
    #1 chk("f_ready_c0", ifuRdy, 1);
    cycle();
    ifuV = 0;
    #1 chk("f_memvalid_c1", memV, 1);
    chk("f_memaddr_c1", memAddr, 64'h8000_0000);
    cycle();
    memRespV = 1; memRespD = 64'h0010_0073;
    #1 chk("f_resp_c2", ifuRespV, 1);
    chk("f_data_c2", ifuRespD, 64'h0010_0073);
    cycle();
    clearIn();
    #1 chk("f_idle_c3", busy, 0);

    // Simultaneous requests with a clear counter.
    ifuV = 1; lsuV = 1; lsuAddr = 64'h100;
    #1 chk("both_lsu_ready", lsuRdy, 1);
    chk("both_ifu_ready", ifuRdy, 0);
    cycle();
    lsuV = 0;
    runTxn();
    ifuV = 1;
    #1 chk("both_ifu_next", ifuRdy, 1);
    cycle();
    ifuV = 0;
    runTxn();

    // Continuous LSU pressure while fetch waits.
    grantCnt = 0; grantLog = '0;
    for (int k = 0; k < 60 && grantCnt < 6; k++) begin
      ifuV = 1; lsuV = 1; memRdy = 1;
      lsuAddr = {$urandom, $urandom};
      memRespV = active && sent;
      cycle();
    end
    chk("starve_pattern", grantLog[5:0], 6'b000010);
    ifuV = 0; lsuV = 0;
    runTxn();

    // Store held while memory stalls.
    lsuV = 1; lsuWen = 1; lsuAddr = 64'h8000_1000;
    lsuWdata = 64'h1122_3344_5566_7788; lsuWmask = 8'h0F;
    cycle();
    lsuV = 0; lsuAddr = '1; lsuWdata = '0; lsuWmask = 8'hF0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("st_valid", memV, 1);
      chk("st_addr", memAddr, 64'h8000_1000);
      chk("st_wdata", memWdata, 64'h1122_3344_5566_7788);
      chk("st_wmask", memWmask, 8'h0F);
      chk("st_wen", memWen, 1);
      cycle();
    end
    memRdy = 1;
    cycle();
    memRdy = 0; memRespV = 1; memRespD = 64'hA5;
    #1 chk("st_ack", lsuRespV, 1);
    cycle();
    clearIn();

    // Reset while waiting, then a stale response.
    ifuV = 1; memRdy = 1;
    cycle();
    ifuV = 0;
    cycle();
    #1 chk("wait_busy", busy, 1);
    doReset();
    clearIn();
    memRespV = 1; memRespD = 64'hDEAD;
    #1 chk("stale_ifu", ifuRespV, 0);
    chk("stale_lsu", lsuRespV, 0);
    chk("stale_busy", busy, 0);
    cycle();

    // Response pulse while idle.
    memRespV = 1;
    cycle();
    memRespV = 0;
    #1 chk("idle_pulse_busy", busy, 0);
    cycle();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) doReset();
      ifuV = ($urandom_range(0, 2) != 0);
      ifuAddr = {$urandom, $urandom};
      lsuV = ($urandom_range(0, 3) != 0);
      lsuAddr = {$urandom, $urandom};
      lsuWen = $urandom_range(0, 1);
      lsuWdata = {$urandom, $urandom};
      lsuWmask = 8'($urandom);
      memRdy = $urandom_range(0, 1);
      memRespV = ($urandom_range(0, 2) == 0);
      memRespD = {$urandom, $urandom};
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, width of all address buses.
REQ-002 Parameter DATA_WIDTH, default 64, width of all data buses.
REQ-003 Parameter STARVE_LIMIT, default 4, max consecutive LSU grants while IFU waits.
REQ-004 Clocking: one clock; reset is asynchronous and active-high. Ports clk and rst carry these and are listed first.
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 ifu_req_valid  in  1  instruction fetch request.
REQ-008 ifu_req_addr  in  ADDR_WIDTH  fetch address (next pc).
REQ-009 ifu_req_ready  out  1  fetch request accepted this cycle.
REQ-010 ifu_resp_valid  out  1  fetch data valid.
REQ-011 ifu_resp_data  out  DATA_WIDTH  fetched data.
REQ-012 lsu_req_valid  in  1  load/store request.
REQ-013 lsu_req_addr  in  ADDR_WIDTH  load/store address (alu result).
REQ-014 lsu_req_wen  in  1  1 = store, 0 = load.
REQ-015 lsu_req_wdata  in  DATA_WIDTH  store data.
REQ-016 lsu_req_wmask  in  8  byte write mask.
REQ-017 lsu_req_ready  out  1  LSU request accepted this cycle.
REQ-018 lsu_resp_valid  out  1  load data / store ack valid.
REQ-019 lsu_resp_data  out  DATA_WIDTH  load data.
REQ-020 mem_req_valid / mem_req_addr / mem_req_wen / mem_req_wdata / mem_req_wmask  out  1/ADDR_WIDTH/1/DATA_WIDTH/8  shared memory port request.
REQ-021 mem_req_ready  in  1  memory accepts request.
REQ-022 mem_resp_valid / mem_resp_data  in  1/DATA_WIDTH  memory response.
REQ-023 busy  out  1  high whenever state is not IDLE.

Function
REQ-024 FSM states IDLE, REQ, WAIT; at most one transaction outstanding.
REQ-025 IDLE: if any request valid, select one, assert its ready combinationally, register addr/wen/wdata/wmask and owner, go to REQ next cycle; else stay.
REQ-026 Selection: LSU wins when both valid, except IFU wins when starve counter equals STARVE_LIMIT.
REQ-027 Starve counter: +1 on LSU grant while ifu_req_valid high; cleared on IFU grant; saturates at STARVE_LIMIT.
REQ-028 IFU transactions drive mem_req_wen = 0, mem_req_wmask = 0.
REQ-029 REQ: mem_req_valid = 1 with registered fields held stable; on mem_req_ready go to WAIT.
REQ-030 WAIT: on mem_resp_valid, owner's resp_valid = 1 same cycle, resp_data = mem_resp_data, go to IDLE; non-owner resp_valid = 0.
REQ-031 Stores complete only on mem_resp_valid (ack); lsu_resp_data then carries mem_resp_data unqualified.
REQ-032 Minimum latency: accept cycle N, mem_req_valid N+1, response earliest N+2; next accept earliest N+3.
REQ-033 mem_resp_valid outside WAIT is ignored; no output changes.
REQ-034 Both ready outputs are 0 outside IDLE; at most one ready high per cycle.
REQ-035 Request inputs may change while not ready; arbiter never samples them outside the accept cycle.

Reset
REQ-036 rst high: state IDLE, starve counter 0, owner IFU, registered fields 0; all outputs 0 immediately (async).
REQ-037 Reset mid-transaction abandons it; a later stale mem_resp_valid is ignored per REQ-033.

Verification
REQ-038 IFU only, addr 0x80000000, mem ready same cycle, resp data 0x00100073 one cycle later -> ifu_req_ready cycle 0, mem_req_valid cycle 1, ifu_resp_valid with 0x00100073 cycle 2.
REQ-039 Both valid in same cycle, counter 0 -> LSU granted, IFU ready 0; IFU granted on next IDLE.
REQ-040 LSU valid continuously plus IFU valid, STARVE_LIMIT 4 -> grants L,L,L,L,I,L...
REQ-041 LSU store addr 0x80001000, wdata 0x1122334455667788, wmask 0x0F, mem_req_ready low 3 cycles -> mem_req fields stable all 3 cycles, wen 1, wmask 0x0F.
REQ-042 rst asserted in WAIT, then mem_resp_valid pulsed after release -> no resp_valid on either side, busy 0.
REQ-043 mem_resp_valid pulsed in IDLE -> no resp_valid, state stays IDLE.
